spi_reg_bank: RTL and testbench

Parametrised register bank behind the rPi SPI front end. It replaces the fixed per-register if/else decode with a generic map of three parts: read/write control registers, read-only status inputs, and a sticky interrupt block with a mask. It adds burst access with address auto-increment within one chip-select transaction. It also adds per-register write and read pulses, so downstream blocks (FIR coefficient loader, EQ, SRAM and MPIO bridges, rotary encoder) need no address compares of their own.

---
 rtl/spi_reg_pkg.sv | 25 ++
 rtl/spi_reg_bank_if.sv | 25 ++
 rtl/spi_irq_collector.sv | 39 +++
 rtl/spi_reg_bank.sv | 116 +++++++++++
 tb/tb_spi_reg_bank.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared address map and helpers for the SPI register bank.
// Map-dependent addresses derive from the register count.
package spi_reg_pkg;

  localparam logic [7:0] UNMAPPED_RD_DEF = 8'h99;

  localparam int AUD_CONTROL  = 'h00;
  localparam int COEF_SEL     = 'h03;
  localparam int FIR_COEF_LSB = 'h04;
  localparam int FIR_COEF_MSB = 'h05;
  localparam int EQ_SEL       = 'h06;
  localparam int SRAM_ADDR    = 'h08;
  localparam int MPIO_CTRL    = 'h0c;
  localparam int ROT_ENC      = 'h14;
  localparam int VU_TEST      = 'h1a;

  function automatic int irq_status_addr(int n);
    return n - 2;
  endfunction

  function automatic int irq_mask_addr(int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// Strobe/address/data bundle between the SPI front end
// and the register bank.
interface spi_reg_bank_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              spi_rd_stb;
  logic              spi_wr_stb;
  logic              spi_end_stb;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wr_data;
  logic [DATA_W-1:0] spi_rd_data;

  modport master (
    output spi_rd_stb, spi_wr_stb, spi_end_stb,
    output spi_addr, spi_wr_data,
    input  spi_rd_data
  );

  modport slave (
    input  spi_rd_stb, spi_wr_stb, spi_end_stb,
    input  spi_addr, spi_wr_data,
    output spi_rd_data
  );
endinterface

// File: rtl/spi_irq_collector.sv
// Sticky edge-triggered interrupt status with W1C clear,
// a mask register and a registered irq output.
module spi_irq_collector #(
  parameter int IRQ_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_W-1:0] irq_in,
  input  logic             clr_we,
  input  logic [IRQ_W-1:0] clr_data,
  input  logic             mask_we,
  input  logic [IRQ_W-1:0] mask_data,
  output logic [IRQ_W-1:0] status,
  output logic [IRQ_W-1:0] mask,
  output logic             irq
);
  logic [IRQ_W-1:0] irq_q;
  logic [IRQ_W-1:0] edge_det;
  logic [IRQ_W-1:0] clr;

  assign edge_det = irq_in ^ irq_q;
  assign clr      = clr_we ? clr_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q  <= '0;
      status <= '0;
      mask   <= '0;
      irq    <= 1'b0;
    end else begin
      irq_q  <= irq_in;
      // a new edge outranks a clear on the same bit
      status <= (status & ~clr) | edge_det;
      if (mask_we)
        mask <= mask_data;
      irq    <= |(status & mask);
    end
  end
endmodule

// File: rtl/spi_reg_bank.sv
// Generic control/status/interrupt register map behind the
// SPI front end, with burst auto-increment and access pulses.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int         DATA_W      = 8,
  parameter int         ADDR_W      = 7,
  parameter int         NUM_REGS    = 32,
  parameter int         RO_BASE     = 20,
  parameter int         NUM_RO      = NUM_REGS - RO_BASE - 2,
  parameter int         IRQ_W       = 8,
  parameter int         AUTO_INC    = 1,
  parameter logic [7:0] UNMAPPED_RD = UNMAPPED_RD_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  spi_reg_bank_if.slave             spi,
  output logic [RO_BASE*DATA_W-1:0] ctrl_regs,
  input  logic [NUM_RO*DATA_W-1:0]  status_in,
  output logic [NUM_REGS-1:0]       wr_pulse,
  output logic [NUM_REGS-1:0]       rd_pulse,
  input  logic [IRQ_W-1:0]          irq_in,
  output logic                      irq
);
  localparam int A_STAT = irq_status_addr(NUM_REGS);
  localparam int A_MASK = irq_mask_addr(NUM_REGS);
  localparam logic [DATA_W-1:0] UNM = DATA_W'(UNMAPPED_RD);
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  logic [DATA_W-1:0] regs [RO_BASE];
  logic [ADDR_W-1:0] ptr;
  logic              ptr_vld;
  logic [ADDR_W-1:0] eff;
  logic [31:0]       e32;
  logic              stb, wr, rd, mapped;
  logic [DATA_W-1:0] rv;
  logic [IRQ_W-1:0]  irq_status, irq_mask;

  assign eff = (AUTO_INC != 0 && ptr_vld) ? ptr : spi.spi_addr;
  assign e32    = 32'(eff);
  assign wr     = spi.spi_wr_stb;
  assign rd     = spi.spi_rd_stb & ~spi.spi_wr_stb;
  assign stb    = spi.spi_rd_stb | spi.spi_wr_stb;
  assign mapped = e32 < NUM_REGS;

  for (genvar g = 0; g < RO_BASE; g++) begin : g_flat
    assign ctrl_regs[g*DATA_W +: DATA_W] = regs[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      ptr_vld <= 1'b0;
    end else if (stb) begin
      ptr     <= (e32 == NUM_REGS-1) ? '0 : eff + 1'b1;
      ptr_vld <= ~spi.spi_end_stb;
    end else if (spi.spi_end_stb) begin
      ptr_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RO_BASE; i++)
        regs[i] <= '0;
    end else if (wr) begin
      for (int i = 0; i < RO_BASE; i++)
        if (e32 == i)
          regs[i] <= spi.spi_wr_data;
    end
  end

  always_comb begin
    rv = UNM;
    for (int i = 0; i < RO_BASE; i++)
      if (e32 == i)
        rv = regs[i];
    for (int i = 0; i < NUM_RO; i++)
      if (e32 == RO_BASE + i)
        rv = status_in[i*DATA_W +: DATA_W];
    if (e32 == A_STAT) begin
      rv = '0;
      rv[IRQ_W-1:0] = irq_status;
    end
    if (e32 == A_MASK) begin
      rv = '0;
      rv[IRQ_W-1:0] = irq_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi.spi_rd_data <= '0;
      wr_pulse        <= '0;
      rd_pulse        <= '0;
    end else begin
      wr_pulse <= (wr && mapped) ? ONE << eff : '0;
      rd_pulse <= (rd && mapped) ? ONE << eff : '0;
      if (rd)
        spi.spi_rd_data <= rv;
    end
  end

  spi_irq_collector #(.IRQ_W(IRQ_W)) u_irq (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .clr_we    (wr && e32 == A_STAT),
    .clr_data  (spi.spi_wr_data[IRQ_W-1:0]),
    .mask_we   (wr && e32 == A_MASK),
    .mask_data (spi.spi_wr_data[IRQ_W-1:0]),
    .status    (irq_status),
    .mask      (irq_mask),
    .irq       (irq)
  );
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed checks of the register bank: map, burst,
// status reads, interrupts, reset and rd/wr collisions.
module tb_spi_reg_bank;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [159:0] ctrl_regs;
  logic [79:0]  status_in = '0;
  logic [31:0]  wr_pulse;
  logic [31:0]  rd_pulse;
  logic [7:0]   irq_in = '0;
  logic         irq;
  int           n_chk = 0;
  int           n_fail = 0;

  spi_reg_bank_if #(.ADDR_W(7), .DATA_W(8)) bus ();

  spi_reg_bank dut (
    .clk       (clk),
    .reset     (reset),
    .spi       (bus.slave),
    .ctrl_regs (ctrl_regs),
    .status_in (status_in),
    .wr_pulse  (wr_pulse),
    .rd_pulse  (rd_pulse),
    .irq_in    (irq_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cr(int i);
    return ctrl_regs[i*8 +: 8];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.spi_addr    = a;
    bus.spi_wr_data = d;
    bus.spi_wr_stb  = 1'b1;
    @(negedge clk);
    bus.spi_wr_stb  = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a);
    @(negedge clk);
    bus.spi_addr   = a;
    bus.spi_rd_stb = 1'b1;
    @(negedge clk);
    bus.spi_rd_stb = 1'b0;
  endtask

  task automatic endt();
    @(negedge clk);
    bus.spi_end_stb = 1'b1;
    @(negedge clk);
    bus.spi_end_stb = 1'b0;
  endtask

  initial begin
    bus.spi_rd_stb  = 1'b0;
    bus.spi_wr_stb  = 1'b0;
    bus.spi_end_stb = 1'b0;
    bus.spi_addr    = '0;
    bus.spi_wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'(ctrl_regs[63:0]), 64'h0);
    chk("rst_rdata", 64'(bus.spi_rd_data), 64'h0);
    chk("rst_wrp", 64'(wr_pulse), 64'h0);
    chk("rst_rdp", 64'(rd_pulse), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    reset = 1'b0;

    wr(7'd3, 8'hA5);
    chk("wr3_val", 64'(cr(3)), 64'hA5);
    chk("wr3_pulse", 64'(wr_pulse), 64'(32'h1 << 3));
    @(negedge clk);
    chk("wr3_pulse_end", 64'(wr_pulse), 64'h0);
    endt();
    rd(7'd3);
    chk("rd3_val", 64'(bus.spi_rd_data), 64'hA5);
    chk("rd3_pulse", 64'(rd_pulse), 64'(32'h1 << 3));
    endt();

    wr(7'd30, 8'h11);
    chk("burst_p30", 64'(wr_pulse), 64'(32'h1 << 30));
    wr(7'd0, 8'h22);
    chk("burst_p31", 64'(wr_pulse), 64'(32'h1 << 31));
    wr(7'd9, 8'h33);
    chk("burst_wrap", 64'(cr(0)), 64'h33);
    chk("burst_no9", 64'(cr(9)), 64'h0);
    endt();
    wr(7'd5, 8'h44);
    chk("after_end", 64'(cr(5)), 64'h44);
    endt();
    rd(7'd31);
    chk("mask_rd", 64'(bus.spi_rd_data), 64'h22);
    endt();
    rd(7'd30);
    chk("stat_w1c0", 64'(bus.spi_rd_data), 64'h0);
    endt();

    status_in[47:40] = 8'h3C;
    rd(7'd25);
    chk("ro25_val", 64'(bus.spi_rd_data), 64'h3C);
    chk("ro25_pulse", 64'(rd_pulse), 64'(32'h1 << 25));
    endt();
    wr(7'd25, 8'hFF);
    chk("ro25_wrp", 64'(wr_pulse), 64'(32'h1 << 25));
    endt();
    rd(7'd25);
    chk("ro25_kept", 64'(bus.spi_rd_data), 64'h3C);
    endt();
    rd(7'h40);
    chk("unmapped", 64'(bus.spi_rd_data), 64'h99);
    chk("unm_nopulse", 64'(rd_pulse), 64'h0);
    endt();

    wr(7'd31, 8'h01);
    endt();
    @(negedge clk);
    irq_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("irq_set", 64'(irq), 64'h1);
    rd(7'd30);
    chk("irq_stat", 64'(bus.spi_rd_data), 64'h01);
    endt();
    wr(7'd30, 8'h01);
    @(negedge clk);
    chk("irq_clr", 64'(irq), 64'h0);
    endt();
    @(negedge clk);
    irq_in[0]       = 1'b0;
    bus.spi_addr    = 7'd30;
    bus.spi_wr_data = 8'h01;
    bus.spi_wr_stb  = 1'b1;
    @(negedge clk);
    bus.spi_wr_stb  = 1'b0;
    endt();
    rd(7'd30);
    chk("set_wins", 64'(bus.spi_rd_data), 64'h01);
    chk("set_wins_irq", 64'(irq), 64'h1);
    endt();

    wr(7'd10, 8'hAA);
    wr(7'd0, 8'hBB);
    chk("pre_rst11", 64'(cr(11)), 64'hBB);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst10", 64'(cr(10)), 64'h0);
    chk("mid_rst11", 64'(cr(11)), 64'h0);
    chk("mid_rst_rd", 64'(bus.spi_rd_data), 64'h0);
    chk("mid_rst_irq", 64'(irq), 64'h0);
    reset = 1'b0;
    wr(7'd7, 8'h77);
    chk("post_rst7", 64'(cr(7)), 64'h77);
    chk("post_rst12", 64'(cr(12)), 64'h0);
    endt();

    rd(7'h40);
    endt();
    @(negedge clk);
    bus.spi_addr    = 7'd2;
    bus.spi_wr_data = 8'h5A;
    bus.spi_wr_stb  = 1'b1;
    bus.spi_rd_stb  = 1'b1;
    @(negedge clk);
    bus.spi_wr_stb  = 1'b0;
    bus.spi_rd_stb  = 1'b0;
    chk("both_wr", 64'(cr(2)), 64'h5A);
    chk("both_rdata", 64'(bus.spi_rd_data), 64'h99);
    chk("both_rdp", 64'(rd_pulse), 64'h0);
    chk("both_wrp", 64'(wr_pulse), 64'(32'h1 << 2));
    wr(7'd0, 8'h66);
    chk("both_adv", 64'(cr(3)), 64'h66);
    endt();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
